// File: rtl/cnn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cnn_pkg
//  Description : Shared CNN types: default logit width, logit type and the
//                argmax classifier state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package cnn_pkg;

    localparam int DATA_WIDTH = 16;

    typedef logic signed [DATA_WIDTH-1:0] logit_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        FINISH = 2'd2
    } state_t;

endpackage : cnn_pkg
`default_nettype wire

// File: rtl/argmax_classifier.sv
`default_nettype none
// ============================================================================
//  Module      : argmax_classifier
//  Description : Snapshots a signed logit vector on start, scans it one
//                element per cycle and reports the index/value of the largest
//                logit (lowest index wins ties) with a one-cycle done pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module argmax_classifier
    import cnn_pkg::*;
#(
    parameter  int DATA_WIDTH  = cnn_pkg::DATA_WIDTH,
    parameter  int NUM_CLASSES = 10,
    localparam int IDX_W       = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
)(
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic signed [DATA_WIDTH-1:0] in_vec [0:NUM_CLASSES-1],
    output logic                         busy,
    output logic                         done,
    output logic        [IDX_W-1:0]      class_idx,
    output logic signed [DATA_WIDTH-1:0] max_val
);

    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(NUM_CLASSES - 1);

    state_t                       r_state;
    state_t                       w_state_next;

    logic signed [DATA_WIDTH-1:0] r_snap [0:NUM_CLASSES-1];
    logic signed [DATA_WIDTH-1:0] r_best_val;
    logic        [IDX_W-1:0]      r_best_idx;
    logic        [IDX_W-1:0]      r_idx;

    logic                         w_load;
    logic                         w_last;
    logic signed [DATA_WIDTH-1:0] w_cand;
    logic                         w_take;
    logic signed [DATA_WIDTH-1:0] w_scan_val;
    logic        [IDX_W-1:0]      w_scan_idx;

    // A new vector is only accepted when no scan is running
    assign w_load     = start && (r_state != SCAN);
    assign w_last     = (r_idx == c_LAST_IDX);
    assign w_cand     = r_snap[r_idx];
    // Strict compare keeps the earlier index on a tie
    assign w_take     = (w_cand > r_best_val);
    assign w_scan_val = w_take ? w_cand : r_best_val;
    assign w_scan_idx = w_take ? r_idx  : r_best_idx;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and status outputs
    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = (NUM_CLASSES == 1) ? FINISH : SCAN;
                end
            end
            SCAN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_next = FINISH;
                end
            end
            FINISH: begin
                done = 1'b1;
                if (start) begin
                    w_state_next = (NUM_CLASSES == 1) ? FINISH : SCAN;
                end else begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Snapshot capture and running-best tracking
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int j = 0; j < NUM_CLASSES; j++) begin
                r_snap[j] <= '0;
            end
            r_best_val <= '0;
            r_best_idx <= '0;
            r_idx      <= '0;
        end else if (w_load) begin
            for (int j = 0; j < NUM_CLASSES; j++) begin
                r_snap[j] <= in_vec[j];
            end
            r_best_val <= in_vec[0];
            r_best_idx <= '0;
            r_idx      <= IDX_W'(1);
        end else if (r_state == SCAN) begin
            r_best_val <= w_scan_val;
            r_best_idx <= w_scan_idx;
            if (!w_last) begin
                r_idx <= r_idx + IDX_W'(1);
            end
        end
    end

    // Result registers update only on the edge that enters FINISH
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            class_idx <= '0;
            max_val   <= '0;
        end else if (w_load && (NUM_CLASSES == 1)) begin
            class_idx <= '0;
            max_val   <= in_vec[0];
        end else if ((r_state == SCAN) && w_last) begin
            class_idx <= w_scan_idx;
            max_val   <= w_scan_val;
        end
    end

endmodule : argmax_classifier
`default_nettype wire
